// File: rtl/alice4_zbuf_pkg.sv
// Shared Z-buffer definitions: compare-function encodings, the depth compare
// itself, and the width of one packed pixel-FIFO entry.
package alice4_zbuf_pkg;

  typedef enum logic [2:0] {
    Z_NEVER    = 3'd0,
    Z_LESS     = 3'd1,
    Z_EQUAL    = 3'd2,
    Z_LEQUAL   = 3'd3,
    Z_GREATER  = 3'd4,
    Z_NOTEQUAL = 3'd5,
    Z_GEQUAL   = 3'd6,
    Z_ALWAYS   = 3'd7
  } z_func_t;

  // Compare operands are zero-extended to this width, so any Z_WIDTH up to it works.
  localparam int Z_CMP_WIDTH = 64;

  function automatic logic z_compare(input logic [Z_CMP_WIDTH-1:0] a,
                                     input logic [Z_CMP_WIDTH-1:0] b,
                                     input z_func_t func);
    logic result;
    result = 1'b0;
    case (func)
      Z_NEVER:    result = 1'b0;
      Z_LESS:     result = (a < b);
      Z_EQUAL:    result = (a == b);
      Z_LEQUAL:   result = (a <= b);
      Z_GREATER:  result = (a > b);
      Z_NOTEQUAL: result = (a != b);
      Z_GEQUAL:   result = (a >= b);
      Z_ALWAYS:   result = 1'b1;
    endcase
    return result;
  endfunction

  // z_active + z_func + two addresses + colour + per-pixel Z and enable.
  function automatic int entry_width(input int pixels, input int z_width,
                                     input int addr_width, input int color_width);
    return 4 + 2 * addr_width + color_width + pixels * (z_width + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   usedw
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg;
  logic [DEPTH_LOG2:0] rd_ptr_reg;
  logic                wr_ok;
  logic                rd_ok;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign usedw   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (usedw == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (usedw == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/z_test_read_fifo.sv
// Z read stage: holds fragment words until their Z word returns, depth-tests
// each pixel and forwards survivors to the write FIFO.
module z_test_read_fifo
  import alice4_zbuf_pkg::*;
#(
  parameter int PIXELS_PER_WORD = 2,
  parameter int Z_WIDTH         = 32,
  parameter int ADDR_WIDTH      = 29,
  parameter int COLOR_WIDTH     = 64,
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [PIXELS_PER_WORD*Z_WIDTH-1:0] read_readdata,
  input  logic                               read_readdatavalid,
  input  logic                               enqueue,
  output logic                               in_ready,
  input  logic                               z_active,
  input  logic [2:0]                         z_func,
  input  logic [ADDR_WIDTH-1:0]              color_address,
  input  logic [COLOR_WIDTH-1:0]             color,
  input  logic [ADDR_WIDTH-1:0]              z_address,
  input  logic [PIXELS_PER_WORD*Z_WIDTH-1:0] z,
  input  logic [PIXELS_PER_WORD-1:0]         pixel_active,
  output logic [FIFO_DEPTH_LOG2:0]           size,
  output logic                               write_valid,
  input  logic                               write_ready,
  output logic [ADDR_WIDTH-1:0]              write_color_address,
  output logic [COLOR_WIDTH-1:0]             write_color,
  output logic [ADDR_WIDTH-1:0]              write_z_address,
  output logic [PIXELS_PER_WORD*Z_WIDTH-1:0] write_z,
  output logic [PIXELS_PER_WORD-1:0]         write_pixel_active,
  output logic [31:0]                        culled_count,
  output logic                               z_overflow
);

  localparam int ZW          = PIXELS_PER_WORD * Z_WIDTH;
  localparam int ENTRY_WIDTH = entry_width(PIXELS_PER_WORD, Z_WIDTH, ADDR_WIDTH, COLOR_WIDTH);

  logic [ENTRY_WIDTH-1:0]     pix_wr_data;
  logic [ENTRY_WIDTH-1:0]     pix_rd_data;
  logic                       pix_full;
  logic                       pix_empty;
  logic [ZW-1:0]              mem_z;
  logic                       z_full;
  logic                       z_empty;
  logic [FIFO_DEPTH_LOG2:0]   z_usedw;

  logic                       head_z_active;
  logic [2:0]                 head_z_func;
  logic [ADDR_WIDTH-1:0]      head_color_address;
  logic [COLOR_WIDTH-1:0]     head_color;
  logic [ADDR_WIDTH-1:0]      head_z_address;
  logic [ZW-1:0]              head_z;
  logic [PIXELS_PER_WORD-1:0] head_pixel_active;

  logic [PIXELS_PER_WORD-1:0] pass;
  logic [PIXELS_PER_WORD-1:0] new_active;
  logic                       z_avail;
  logic                       can_pop;
  logic                       cull;

  assign pix_wr_data = {z_active, z_func, color_address, color, z_address, z, pixel_active};
  assign {head_z_active, head_z_func, head_color_address, head_color,
          head_z_address, head_z, head_pixel_active} = pix_rd_data;

  sync_fifo #(
    .WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) pixel_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (enqueue),
    .wr_data (pix_wr_data),
    .rd_en   (can_pop),
    .rd_data (pix_rd_data),
    .full    (pix_full),
    .empty   (pix_empty),
    .usedw   (size)
  );

  sync_fifo #(
    .WIDTH(ZW), .DEPTH(FIFO_DEPTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) z_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (read_readdatavalid),
    .wr_data (read_readdata),
    .rd_en   (can_pop && head_z_active),
    .rd_data (mem_z),
    .full    (z_full),
    .empty   (z_empty),
    .usedw   (z_usedw)
  );

  assign in_ready = !pix_full;
  assign z_avail  = !z_empty && (z_usedw != '0);

  // Fragment Z is the left operand of the compare.
  generate
    for (genvar gi = 0; gi < PIXELS_PER_WORD; gi++) begin : g_test
      assign pass[gi] = z_compare(Z_CMP_WIDTH'(head_z[gi*Z_WIDTH +: Z_WIDTH]),
                                  Z_CMP_WIDTH'(mem_z[gi*Z_WIDTH +: Z_WIDTH]),
                                  z_func_t'(head_z_func));
    end
  endgenerate

  assign new_active = head_z_active ? (head_pixel_active & pass) : head_pixel_active;
  assign cull       = head_z_active && (new_active == '0);
  assign can_pop    = (!write_valid || write_ready) && !pix_empty &&
                      (!head_z_active || z_avail);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_valid         <= 1'b0;
      write_color_address <= '0;
      write_color         <= '0;
      write_z_address     <= '0;
      write_z             <= '0;
      write_pixel_active  <= '0;
      culled_count        <= '0;
      z_overflow          <= 1'b0;
    end else begin
      if (can_pop) begin
        // A pop implies any held word was just accepted, so a cull leaves the register empty.
        if (cull) begin
          write_valid <= 1'b0;
          if (culled_count != '1) culled_count <= culled_count + 32'd1;
        end else begin
          write_valid         <= 1'b1;
          write_color_address <= head_color_address;
          write_color         <= head_color;
          write_z_address     <= head_z_address;
          write_z             <= head_z;
          write_pixel_active  <= new_active;
        end
      end else if (write_ready) begin
        write_valid <= 1'b0;
      end
      if (read_readdatavalid && z_full) z_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_z_test_read_fifo.sv
// Directed bench for z_test_read_fifo: pass-through, depth functions, culling,
// full FIFO, backpressure, Z overflow and asynchronous reset.
module tb_z_test_read_fifo;
  import alice4_zbuf_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [63:0]  read_readdata = '0;
  logic         read_readdatavalid = 1'b0;
  logic         enqueue = 1'b0;
  logic         in_ready;
  logic         z_active = 1'b0;
  logic [2:0]   z_func = 3'd0;
  logic [28:0]  color_address = '0;
  logic [63:0]  color = '0;
  logic [28:0]  z_address = '0;
  logic [63:0]  z = '0;
  logic [1:0]   pixel_active = '0;
  logic [5:0]   size;
  logic         write_valid;
  logic         write_ready = 1'b1;
  logic [28:0]  write_color_address;
  logic [63:0]  write_color;
  logic [28:0]  write_z_address;
  logic [63:0]  write_z;
  logic [1:0]   write_pixel_active;
  logic [31:0]  culled_count;
  logic         z_overflow;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  z_test_read_fifo dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .read_readdata       (read_readdata),
    .read_readdatavalid  (read_readdatavalid),
    .enqueue             (enqueue),
    .in_ready            (in_ready),
    .z_active            (z_active),
    .z_func              (z_func),
    .color_address       (color_address),
    .color               (color),
    .z_address           (z_address),
    .z                   (z),
    .pixel_active        (pixel_active),
    .size                (size),
    .write_valid         (write_valid),
    .write_ready         (write_ready),
    .write_color_address (write_color_address),
    .write_color         (write_color),
    .write_z_address     (write_z_address),
    .write_z             (write_z),
    .write_pixel_active  (write_pixel_active),
    .culled_count        (culled_count),
    .z_overflow          (z_overflow)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frag(input logic za, input logic [2:0] f, input logic [63:0] col,
                          input logic [31:0] z0, input logic [31:0] z1, input logic [1:0] pa);
    z_active      = za;
    z_func        = f;
    color         = col;
    color_address = col[28:0] + 29'd5;
    z_address     = col[28:0] + 29'd9;
    z             = {z1, z0};
    pixel_active  = pa;
  endtask

  task automatic enq(input logic za, input logic [2:0] f, input logic [63:0] col,
                     input logic [31:0] z0, input logic [31:0] z1, input logic [1:0] pa);
    set_frag(za, f, col, z0, z1, pa);
    enqueue = 1'b1;
    tick();
    enqueue = 1'b0;
  endtask

  task automatic zret(input logic [31:0] z0, input logic [31:0] z1);
    read_readdata      = {z1, z0};
    read_readdatavalid = 1'b1;
    tick();
    read_readdatavalid = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(); tick();
    check("rst_valid", write_valid, 0);
    check("rst_culled", culled_count, 0);
    check("rst_ovf", z_overflow, 0);
    check("rst_size", size, 0);
    check("rst_color", write_color, 0);
    #2 reset_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Pass-through: z_active=0 ignores even NEVER
    enq(1'b0, Z_NEVER, 64'h100, 1, 2, 2'b11);
    check("pt_size0", size, 1);
    check("pt_valid0", write_valid, 0);
    enq(1'b0, Z_NEVER, 64'h101, 1, 2, 2'b10);
    check("pt_valid1", write_valid, 1);
    check("pt_color1", write_color, 64'h100);
    check("pt_act1", write_pixel_active, 2'b11);
    check("pt_caddr1", write_color_address, 29'h105);
    check("pt_size1", size, 1);
    enq(1'b0, Z_NEVER, 64'h102, 1, 2, 2'b01);
    check("pt_color2", write_color, 64'h101);
    check("pt_act2", write_pixel_active, 2'b10);
    tick();
    check("pt_color3", write_color, 64'h102);
    check("pt_act3", write_pixel_active, 2'b01);
    check("pt_zaddr3", write_z_address, 29'h10b);
    tick();
    check("pt_idle", write_valid, 0);
    check("pt_culled", culled_count, 0);

    // LEQUAL: {5,9} vs {7,8} -> only pixel 0 survives
    enq(1'b1, Z_LEQUAL, 64'h200, 5, 9, 2'b11);
    check("leq_wait", write_valid, 0);
    zret(7, 8);
    check("leq_same_cycle", write_valid, 0);
    tick();
    check("leq_valid", write_valid, 1);
    check("leq_act", write_pixel_active, 2'b01);
    check("leq_z", write_z, {32'd9, 32'd5});

    // Per-entry mode: LESS entry culled, following EQUAL entry passes
    enq(1'b1, Z_LESS, 64'h300, 10, 10, 2'b11);
    enq(1'b1, Z_EQUAL, 64'h301, 10, 10, 2'b11);
    zret(3, 3);
    zret(10, 10);
    check("less_cull_valid", write_valid, 0);
    check("less_culled", culled_count, 1);
    tick();
    check("eq_valid", write_valid, 1);
    check("eq_color", write_color, 64'h301);
    check("eq_act", write_pixel_active, 2'b11);
    check("eq_culled", culled_count, 1);

    // GREATER {6,2} vs {5,5}, then NEVER culls
    enq(1'b1, Z_GREATER, 64'h400, 6, 2, 2'b11);
    zret(5, 5);
    tick();
    check("gt_act", write_pixel_active, 2'b01);
    enq(1'b1, Z_NEVER, 64'h401, 6, 2, 2'b11);
    zret(5, 5);
    tick();
    check("never_valid", write_valid, 0);
    check("never_culled", culled_count, 2);

    // Fill 32 entries with no Z returned; 33rd enqueue dropped
    enqueue = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_frag(1'b1, Z_ALWAYS, 64'h1000 + 64'(i), i, i, 2'b11);
      tick();
    end
    check("full_size", size, 32);
    check("full_in_ready", in_ready, 0);
    set_frag(1'b1, Z_ALWAYS, 64'h2000, 0, 0, 2'b11);
    tick();
    enqueue = 1'b0;
    check("full_drop_size", size, 32);
    check("full_no_out", write_valid, 0);
    for (int k = 0; k <= 32; k++) begin
      read_readdata      = {32'(k), 32'(k)};
      read_readdatavalid = (k < 32);
      tick();
      if (k >= 1) begin
        check("drain_valid", write_valid, 1);
        check("drain_color", write_color, 64'h1000 + 64'(k - 1));
      end
    end
    read_readdatavalid = 1'b0;
    check("drain_size", size, 0);
    tick();
    check("drain_done", write_valid, 0);

    // Backpressure: stall 5 clocks, then full-rate release
    write_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_frag(1'b1, Z_ALWAYS, 64'h500 + 64'(i), 1, 1, 2'b11);
      read_readdata      = {32'd2, 32'd2};
      enqueue            = 1'b1;
      read_readdatavalid = 1'b1;
      tick();
    end
    enqueue = 1'b0;
    read_readdatavalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", write_valid, 1);
      check("stall_color", write_color, 64'h500);
      check("stall_size", size, 2);
      tick();
    end
    write_ready = 1'b1;
    tick();
    check("rel_color1", write_color, 64'h501);
    check("rel_valid1", write_valid, 1);
    tick();
    check("rel_color2", write_color, 64'h502);
    tick();
    check("rel_done", write_valid, 0);
    check("rel_ovf", z_overflow, 0);

    // Z overflow: 33 words with no consumers
    write_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      read_readdata      = {32'd3, 32'd3};
      read_readdatavalid = 1'b1;
      tick();
      if (i == 31) check("ovf_not_yet", z_overflow, 0);
    end
    read_readdatavalid = 1'b0;
    check("ovf_set", z_overflow, 1);
    enq(1'b1, Z_ALWAYS, 64'h77, 0, 0, 2'b11);
    tick();
    check("pre_rst_valid", write_valid, 1);
    check("pre_rst_color", write_color, 64'h77);
    enq(1'b0, Z_ALWAYS, 64'h78, 0, 0, 2'b11);
    enq(1'b0, Z_ALWAYS, 64'h79, 0, 0, 2'b11);
    check("pre_rst_size", size, 2);

    // Asynchronous reset mid-stream
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", write_valid, 0);
    check("arst_culled", culled_count, 0);
    check("arst_ovf", z_overflow, 0);
    check("arst_size", size, 0);
    check("arst_color", write_color, 0);
    check("arst_z", write_z, 0);
    #3 reset_n = 1'b1;
    write_ready = 1'b1;
    enq(1'b1, Z_ALWAYS, 64'h88, 0, 0, 2'b11);
    tick(); tick();
    check("post_rst_zempty", write_valid, 0);
    check("post_rst_size", size, 1);
    zret(1, 1);
    tick();
    check("post_rst_valid", write_valid, 1);
    check("post_rst_color", write_color, 64'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
